// File: rtl/chess_turn_controller_if.sv
// Board-side signal bundle of the chess turn controller: raw buttons, timer
// timeouts in; timer run flags, game status out.
interface chess_turn_controller_if;
   logic       btn_start;
   logic       btn_pause;
   logic       btn_white;
   logic       btn_black;
   logic       white_timeout;
   logic       black_timeout;
   logic       white_flag;
   logic       black_flag;
   logic       paused;
   logic       game_over;
   logic [1:0] winner;
   logic [7:0] move_count;

   modport master (
      output btn_start, btn_pause, btn_white, btn_black,
      output white_timeout, black_timeout,
      input  white_flag, black_flag, paused, game_over, winner, move_count
   );

   modport slave (
      input  btn_start, btn_pause, btn_white, btn_black,
      input  white_timeout, black_timeout,
      output white_flag, black_flag, paused, game_over, winner, move_count
   );
endinterface

// File: rtl/chess_turn_controller.sv
// Chess turn arbiter: debounces the four pushbuttons, alternates the running
// clock between White and Black, handles pause and latches the game result.
module chess_turn_controller #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int CNT_W           = 20
) (
   input  logic                    clock,
   input  logic                    reset,
   chess_turn_controller_if.slave  bus
);

   localparam logic [CNT_W-1:0] DEB_MAX  = CNT_W'(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   localparam int BTN_START = 0;
   localparam int BTN_PAUSE = 1;
   localparam int BTN_WHITE = 2;
   localparam int BTN_BLACK = 3;

   typedef enum logic [2:0] {S_IDLE, S_WHITE, S_BLACK, S_PAUSE, S_OVER} state_e;

   logic [3:0]       raw;
   logic [3:0]       sync1_q;
   logic [3:0]       sync2_q;
   logic [3:0]       press_q;
   logic [CNT_W-1:0] cnt_q [4];

   assign raw = {bus.btn_black, bus.btn_white, bus.btn_pause, bus.btn_start};

   // Counter saturates at DEB_MAX so a held button yields exactly one press.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
         press_q <= '0;
         for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
      end else begin
         // NOTE: non-blocking assignments keep the two synchronizer stages as
         // separate flops; a blocking '=' here would collapse them into one.
         sync1_q <= raw;
         sync2_q <= sync1_q;
         for (int i = 0; i < 4; i++) begin
            press_q[i] <= 1'b0;
            if (!sync2_q[i]) begin
               cnt_q[i] <= '0;
            end else if (cnt_q[i] != DEB_MAX) begin
               cnt_q[i]   <= cnt_q[i] + 1'b1;
               press_q[i] <= (cnt_q[i] == DEB_LAST);
            end
         end
      end
   end

   state_e     state_q, state_d;
   logic       side_q, side_d;
   logic [7:0] count_q, count_d;
   logic [1:0] winner_q, winner_d;
   logic       timeout;
   logic       move_ok;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         side_q   <= 1'b0;
         count_q  <= '0;
         winner_q <= '0;
      end else begin
         state_q  <= state_d;
         side_q   <= side_d;
         count_q  <= count_d;
         winner_q <= winner_d;
      end
   end

   // Priority in play: timeout, then the mover's own press, then pause.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves it
      // unassigned, which would otherwise infer a latch.
      state_d  = state_q;
      side_d   = side_q;
      count_d  = count_q;
      winner_d = winner_q;
      timeout  = bus.white_timeout | bus.black_timeout;
      move_ok  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (press_q[BTN_START]) state_d = S_WHITE;
         end
         S_WHITE, S_BLACK: begin
            move_ok = (state_q == S_WHITE) ? press_q[BTN_WHITE] : press_q[BTN_BLACK];
            if (timeout) begin
               state_d  = S_OVER;
               winner_d = {bus.white_timeout, bus.black_timeout};
            end else if (move_ok) begin
               state_d = (state_q == S_WHITE) ? S_BLACK : S_WHITE;
               if (count_q != 8'hFF) count_d = count_q + 8'd1;
            end else if (press_q[BTN_PAUSE]) begin
               state_d = S_PAUSE;
               side_d  = (state_q == S_BLACK);
            end
         end
         S_PAUSE: begin
            if (timeout) begin
               state_d  = S_OVER;
               winner_d = {bus.white_timeout, bus.black_timeout};
            end else if (press_q[BTN_PAUSE]) begin
               state_d = side_q ? S_BLACK : S_WHITE;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      bus.white_flag = (state_q == S_WHITE);
      bus.black_flag = (state_q == S_BLACK);
      bus.paused     = (state_q == S_PAUSE);
      bus.game_over  = (state_q == S_OVER);
      bus.winner     = winner_q;
      bus.move_count = count_q;
   end

endmodule

// File: tb/tb_chess_turn_controller.sv
// Bench for chess_turn_controller: table-driven scenarios, directed corner
// sequences and random button/timeout traffic checked against a game model.
module tb_chess_turn_controller;

   localparam int DEB = 4;

   localparam int M_IDLE  = 0;
   localparam int M_PLAY  = 1;
   localparam int M_PAUSE = 2;
   localparam int M_OVER  = 3;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   chess_turn_controller_if bus ();

   chess_turn_controller #(.DEBOUNCE_CYCLES(DEB), .CNT_W(4)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   int checks = 0;
   int errors = 0;

   // Game model: phase plus whose turn, driven by debounced presses.
   int m_phase, m_turn, m_saved, m_moves, m_winner;
   int run [4];
   bit hit [4][3];

   typedef struct {
      string      name;
      logic [3:0] btn;
      int         hold;
      logic       wt;
      logic       bt;
      logic [13:0] exp;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic logic [13:0] pack(input logic wf, input logic bf, input logic p,
                                        input logic go, input logic [1:0] w, input logic [7:0] mc);
      return {wf, bf, p, go, w, mc};
   endfunction

   function automatic logic [13:0] dut_out();
      return {bus.white_flag, bus.black_flag, bus.paused, bus.game_over, bus.winner, bus.move_count};
   endfunction

   function automatic logic [13:0] model_out();
      return pack(m_phase == M_PLAY && m_turn == 0, m_phase == M_PLAY && m_turn == 1,
                  m_phase == M_PAUSE, m_phase == M_OVER, 2'(m_winner), 8'(m_moves));
   endfunction

   function automatic void model_reset();
      m_phase = M_IDLE; m_turn = 0; m_saved = 0; m_moves = 0; m_winner = 0;
      for (int i = 0; i < 4; i++) begin
         run[i] = 0;
         for (int j = 0; j < 3; j++) hit[i][j] = 1'b0;
      end
   endfunction

   // A press takes effect three edges after the raw run of highs reaches DEB.
   function automatic void model_edge();
      logic [3:0] raw = {bus.btn_black, bus.btn_white, bus.btn_pause, bus.btn_start};
      bit p [4];
      bit wt = bus.white_timeout;
      bit bt = bus.black_timeout;
      if (!reset) begin
         model_reset();
         return;
      end
      for (int i = 0; i < 4; i++) begin
         p[i] = hit[i][2];
         run[i] = raw[i] ? run[i] + 1 : 0;
         hit[i][2] = hit[i][1];
         hit[i][1] = hit[i][0];
         hit[i][0] = (run[i] == DEB);
      end
      case (m_phase)
         M_IDLE: if (p[0]) begin m_phase = M_PLAY; m_turn = 0; end
         M_PLAY, M_PAUSE: begin
            if (wt || bt) begin
               m_phase  = M_OVER;
               m_winner = (wt ? 2 : 0) + (bt ? 1 : 0);
            end else if (m_phase == M_PLAY && p[2 + m_turn]) begin
               m_turn  = 1 - m_turn;
               m_moves = (m_moves < 255) ? m_moves + 1 : 255;
            end else if (p[1]) begin
               if (m_phase == M_PLAY) begin
                  m_phase = M_PAUSE; m_saved = m_turn;
               end else begin
                  m_phase = M_PLAY;  m_turn = m_saved;
               end
            end
         end
         default: ;
      endcase
   endfunction

   task automatic step();
      @(posedge clock);
      model_edge();
      #1;
      check("model", 32'(dut_out()), 32'(model_out()));
   endtask

   task automatic set_btn(input logic [3:0] b);
      {bus.btn_black, bus.btn_white, bus.btn_pause, bus.btn_start} = b;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      model_reset();
      repeat (3) step();
      reset = 1'b1;
      step();
   endtask

   task automatic press(input logic [3:0] b, input int hold);
      set_btn(b);
      repeat (hold) step();
      set_btn(4'b0);
      repeat (6) step();
   endtask

   vec_t vecs [17];

   initial begin
      set_btn(4'b0);
      bus.white_timeout = 1'b0;
      bus.black_timeout = 1'b0;
      model_reset();

      vecs[0]  = '{"start",          4'b0001, 10, 0, 0, pack(1, 0, 0, 0, 2'b00, 8'd0)};
      vecs[1]  = '{"glitch",         4'b0100,  2, 0, 0, pack(1, 0, 0, 0, 2'b00, 8'd0)};
      vecs[2]  = '{"white_move",     4'b0100, 10, 0, 0, pack(0, 1, 0, 0, 2'b00, 8'd1)};
      vecs[3]  = '{"black_held50",   4'b1000, 50, 0, 0, pack(1, 0, 0, 0, 2'b00, 8'd2)};
      vecs[4]  = '{"white_move2",    4'b0100, 10, 0, 0, pack(0, 1, 0, 0, 2'b00, 8'd3)};
      vecs[5]  = '{"pause_black",    4'b0010, 10, 0, 0, pack(0, 0, 1, 0, 2'b00, 8'd3)};
      vecs[6]  = '{"move_in_pause",  4'b1000, 10, 0, 0, pack(0, 0, 1, 0, 2'b00, 8'd3)};
      vecs[7]  = '{"start_in_pause", 4'b0001, 10, 0, 0, pack(0, 0, 1, 0, 2'b00, 8'd3)};
      vecs[8]  = '{"resume_black",   4'b0010, 10, 0, 0, pack(0, 1, 0, 0, 2'b00, 8'd3)};
      vecs[9]  = '{"start_in_black", 4'b0001, 10, 0, 0, pack(0, 1, 0, 0, 2'b00, 8'd3)};
      vecs[10] = '{"white_in_black", 4'b0100, 10, 0, 0, pack(0, 1, 0, 0, 2'b00, 8'd3)};
      vecs[11] = '{"black_move",     4'b1000, 10, 0, 0, pack(1, 0, 0, 0, 2'b00, 8'd4)};
      vecs[12] = '{"pause_white",    4'b0010, 10, 0, 0, pack(0, 0, 1, 0, 2'b00, 8'd4)};
      vecs[13] = '{"resume_white",   4'b0010, 10, 0, 0, pack(1, 0, 0, 0, 2'b00, 8'd4)};
      vecs[14] = '{"white_timeout",  4'b0000,  1, 1, 0, pack(0, 0, 0, 1, 2'b10, 8'd4)};
      vecs[15] = '{"press_in_over",  4'b1111, 10, 0, 0, pack(0, 0, 0, 1, 2'b10, 8'd4)};
      vecs[16] = '{"timeout_in_over",4'b0000,  1, 0, 1, pack(0, 0, 0, 1, 2'b10, 8'd4)};

      // Reset state and exact press latency.
      do_reset();
      check("reset_outputs", 32'(dut_out()), 32'(pack(0, 0, 0, 0, 2'b00, 8'd0)));
      set_btn(4'b0001);
      repeat (6) step();
      check("latency_edge6", 32'(bus.white_flag), 32'd0);
      step();
      check("latency_edge7", 32'(bus.white_flag), 32'd1);
      check("latency_black", 32'(bus.black_flag), 32'd0);
      repeat (3) step();
      set_btn(4'b0);
      repeat (6) step();

      // Table scenarios from a fresh reset.
      do_reset();
      for (int i = 0; i < 17; i++) begin
         set_btn(vecs[i].btn);
         bus.white_timeout = vecs[i].wt;
         bus.black_timeout = vecs[i].bt;
         repeat (vecs[i].hold) step();
         set_btn(4'b0);
         bus.white_timeout = 1'b0;
         bus.black_timeout = 1'b0;
         repeat (8) step();
         check(vecs[i].name, 32'(dut_out()), 32'(vecs[i].exp));
      end

      // Simultaneous timeouts while Black runs.
      do_reset();
      press(4'b0001, 6);
      press(4'b0100, 6);
      bus.white_timeout = 1'b1;
      bus.black_timeout = 1'b1;
      step();
      bus.white_timeout = 1'b0;
      bus.black_timeout = 1'b0;
      check("draw", 32'(dut_out()), 32'(pack(0, 0, 0, 1, 2'b11, 8'd1)));

      // Timeout on the same edge the White move takes effect.
      do_reset();
      press(4'b0001, 6);
      press(4'b0100, 6);
      press(4'b1000, 6);
      set_btn(4'b0100);
      repeat (6) step();
      bus.white_timeout = 1'b1;
      step();
      bus.white_timeout = 1'b0;
      set_btn(4'b0);
      check("timeout_beats_move", 32'(dut_out()), 32'(pack(0, 0, 0, 1, 2'b10, 8'd2)));
      repeat (6) step();

      // Saturation after 260 moves, then asynchronous reset mid-White.
      do_reset();
      press(4'b0001, 6);
      for (int i = 0; i < 260; i++) press((i % 2 == 0) ? 4'b0100 : 4'b1000, 5);
      check("saturate", 32'(dut_out()), 32'(pack(1, 0, 0, 0, 2'b00, 8'd255)));
      #3;
      reset = 1'b0;
      model_reset();
      #1;
      check("async_reset", 32'(dut_out()), 32'd0);
      step();
      reset = 1'b1;
      step();

      // Random traffic against the model.
      begin
         int over_cycles = 0;
         logic [3:0] b = 4'b0;
         for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 4; k++)
               if ($urandom_range(9) == 0) b[k] = ~b[k];
            set_btn(b);
            bus.white_timeout = ($urandom_range(399) == 0);
            bus.black_timeout = ($urandom_range(399) == 0);
            if (m_phase == M_OVER) over_cycles++;
            if (over_cycles > 30) begin
               over_cycles = 0;
               reset = 1'b0;
               step();
               step();
               reset = 1'b1;
            end
            step();
         end
         set_btn(4'b0);
         bus.white_timeout = 1'b0;
         bus.black_timeout = 1'b0;
         repeat (10) step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
